// File: rtl/axi_read_arbiter_if.sv
// One AXI read port (AR + R channels). The ID width is a parameter so the same
// bundle serves the 4-bit master ports and the 8-bit slave port.
interface axi_read_arbiter_if #(
    parameter int unsigned IdWidth = 4
);
    logic [IdWidth-1:0] ARID;
    logic [31:0]        ARADDR;
    logic [3:0]         ARLEN;
    logic [2:0]         ARSIZE;
    logic [1:0]         ARBURST;
    logic               ARVALID;
    logic               ARREADY;
    logic [IdWidth-1:0] RID;
    logic [31:0]        RDATA;
    logic [1:0]         RRESP;
    logic               RLAST;
    logic               RVALID;
    logic               RREADY;

    // Initiator side: issues AR requests and accepts R beats.
    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    // Target side: accepts AR requests and returns R beats.
    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master, one-slave arbiter for the AXI read channels. One read is in
// flight at a time; the grant is held from the AR handshake until the R beat
// carrying RLAST. Round-robin on contention, M0 first after reset.
module axi_read_arbiter #(
    parameter logic [3:0] MASTER_TAG0 = 4'h0,
    parameter logic [3:0] MASTER_TAG1 = 4'h1
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axi_read_arbiter_if.slave  io_m0,
    axi_read_arbiter_if.slave  io_m1,
    axi_read_arbiter_if.master io_s,
    output logic               id_err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    state_e      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_id_err;
    logic        r_arvalid_s;
    logic [7:0]  r_arid_s;
    logic [31:0] r_araddr_s;
    logic [3:0]  r_arlen_s;
    logic [2:0]  r_arsize_s;
    logic [1:0]  r_arburst_s;

    logic        w_req0;
    logic        w_req1;
    logic        w_pick;
    logic [3:0]  w_grant_tag;
    logic        w_in_addr;
    logic        w_in_data;
    logic        w_tag_match;
    logic        w_fwd;
    logic        w_rready_grant;
    logic        w_sink;
    logic        w_last_hs;

    assign w_req0 = io_m0.ARVALID;
    assign w_req1 = io_m1.ARVALID;

    // On contention the master that did not win last time goes next.
    assign w_pick = (w_req0 && w_req1) ? ~r_last_grant : w_req1;

    assign w_grant_tag    = r_grant ? MASTER_TAG1 : MASTER_TAG0;
    assign w_in_addr      = (r_state == StAddr);
    assign w_in_data      = (r_state == StData);
    assign w_tag_match    = (io_s.RID[7:4] == w_grant_tag);
    assign w_fwd          = w_in_data && w_tag_match;
    assign w_rready_grant = r_grant ? io_m1.RREADY : io_m0.RREADY;
    // A beat whose tag does not belong to the granted master is drained here.
    assign w_sink         = w_in_data && !w_tag_match && io_s.RVALID;
    assign w_last_hs      = w_fwd && io_s.RVALID && w_rready_grant && io_s.RLAST;

    // Arbitration FSM: latch request in IDLE, present it in ADDR, route beats in DATA.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= StIdle;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_id_err     <= 1'b0;
            r_arvalid_s  <= 1'b0;
            r_arid_s     <= 8'h00;
            r_araddr_s   <= 32'h0000_0000;
            r_arlen_s    <= 4'h0;
            r_arsize_s   <= 3'h0;
            r_arburst_s  <= 2'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req0 || w_req1) begin
                        r_grant     <= w_pick;
                        r_arvalid_s <= 1'b1;
                        r_state     <= StAddr;
                        if (w_pick) begin
                            r_arid_s    <= {MASTER_TAG1, io_m1.ARID};
                            r_araddr_s  <= io_m1.ARADDR;
                            r_arlen_s   <= io_m1.ARLEN;
                            r_arsize_s  <= io_m1.ARSIZE;
                            r_arburst_s <= io_m1.ARBURST;
                        end else begin
                            r_arid_s    <= {MASTER_TAG0, io_m0.ARID};
                            r_araddr_s  <= io_m0.ARADDR;
                            r_arlen_s   <= io_m0.ARLEN;
                            r_arsize_s  <= io_m0.ARSIZE;
                            r_arburst_s <= io_m0.ARBURST;
                        end
                    end
                end
                StAddr: begin
                    if (r_arvalid_s && io_s.ARREADY) begin
                        r_arvalid_s  <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= StData;
                    end
                end
                StData: begin
                    if (w_sink) begin
                        r_id_err <= 1'b1;
                    end
                    // ARLEN is not counted; RLAST alone closes the burst.
                    if (w_last_hs) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Slave AR channel comes straight from the latched request.
    assign io_s.ARVALID = r_arvalid_s;
    assign io_s.ARID    = r_arid_s;
    assign io_s.ARADDR  = r_araddr_s;
    assign io_s.ARLEN   = r_arlen_s;
    assign io_s.ARSIZE  = r_arsize_s;
    assign io_s.ARBURST = r_arburst_s;

    // Mismatched beats are always accepted so the slave cannot wedge.
    assign io_s.RREADY = w_in_data && (w_tag_match ? w_rready_grant : 1'b1);

    // The granted master sees the slave AR handshake in the same cycle.
    assign io_m0.ARREADY = w_in_addr && !r_grant && io_s.ARREADY;
    assign io_m1.ARREADY = w_in_addr &&  r_grant && io_s.ARREADY;

    assign io_m0.RVALID = w_fwd && !r_grant && io_s.RVALID;
    assign io_m1.RVALID = w_fwd &&  r_grant && io_s.RVALID;

    // R payload is shared from the slave bus; qualified only by RVALID.
    assign io_m0.RID   = io_s.RID[3:0];
    assign io_m0.RDATA = io_s.RDATA;
    assign io_m0.RRESP = io_s.RRESP;
    assign io_m0.RLAST = io_s.RLAST;
    assign io_m1.RID   = io_s.RID[3:0];
    assign io_m1.RDATA = io_s.RDATA;
    assign io_m1.RRESP = io_s.RRESP;
    assign io_m1.RLAST = io_s.RLAST;

    assign id_err = r_id_err;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a per-cycle vector table plus
// hand-written sequences for AR stall, tag mismatch and reset mid-burst.
module tb_axi_read_arbiter;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    logic id_err;

    always #5 ACLK = ~ACLK;

    axi_read_arbiter_if #(.IdWidth(4)) m0_if ();
    axi_read_arbiter_if #(.IdWidth(4)) m1_if ();
    axi_read_arbiter_if #(.IdWidth(8)) s_if ();

    axi_read_arbiter #(
        .MASTER_TAG0(4'h0),
        .MASTER_TAG1(4'h1)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .io_m0  (m0_if),
        .io_m1  (m1_if),
        .io_s   (s_if),
        .id_err (id_err)
    );

    typedef struct packed {
        logic        av0;
        logic        av1;
        logic        ars;
        logic        rvs;
        logic [7:0]  rid;
        logic        rlast;
        logic        rr0;
        logic        rr1;
        logic [31:0] rdata;
        logic        e_avs;
        logic [7:0]  e_arid;
        logic        e_ar0;
        logic        e_ar1;
        logic        e_rv0;
        logic        e_rv1;
        logic        e_rrs;
        logic        e_err;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic vec_t mk(
        input logic av0, input logic av1, input logic ars, input logic rvs,
        input logic [7:0] rid, input logic rlast, input logic rr0, input logic rr1,
        input logic [31:0] rdata,
        input logic e_avs, input logic [7:0] e_arid, input logic e_ar0, input logic e_ar1,
        input logic e_rv0, input logic e_rv1, input logic e_rrs, input logic e_err);
        vec_t v;
        v.av0 = av0;  v.av1 = av1;  v.ars = ars;  v.rvs = rvs;
        v.rid = rid;  v.rlast = rlast;  v.rr0 = rr0;  v.rr1 = rr1;  v.rdata = rdata;
        v.e_avs = e_avs;  v.e_arid = e_arid;  v.e_ar0 = e_ar0;  v.e_ar1 = e_ar1;
        v.e_rv0 = e_rv0;  v.e_rv1 = e_rv1;  v.e_rrs = e_rrs;  v.e_err = e_err;
        return v;
    endfunction

    // Drive one cycle of inputs, check outputs at the falling edge, then step.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] e_addr;
        logic [3:0]  e_len;
        logic [2:0]  e_size;
        logic [1:0]  e_burst;
        m0_if.ARVALID = v.av0;
        m1_if.ARVALID = v.av1;
        m0_if.RREADY  = v.rr0;
        m1_if.RREADY  = v.rr1;
        s_if.ARREADY  = v.ars;
        s_if.RVALID   = v.rvs;
        s_if.RID      = v.rid;
        s_if.RLAST    = v.rlast;
        s_if.RDATA    = v.rdata;
        s_if.RRESP    = v.rdata[1:0];
        // Expected AR fields follow from which master's ID is in ARID_S.
        case (v.e_arid[3:0])
            4'h3:    begin e_addr = 32'h40; e_len = 4'd0; e_size = 3'd2; e_burst = 2'd1; end
            4'h5:    begin e_addr = 32'h80; e_len = 4'd3; e_size = 3'd1; e_burst = 2'd2; end
            default: begin e_addr = 32'h0;  e_len = 4'd0; e_size = 3'd0; e_burst = 2'd0; end
        endcase
        @(negedge ACLK);
        check({tag, ".arvalid_s"}, 32'(s_if.ARVALID), 32'(v.e_avs));
        check({tag, ".arid_s"},    32'(s_if.ARID),    32'(v.e_arid));
        check({tag, ".araddr_s"},  s_if.ARADDR,       e_addr);
        check({tag, ".arlen_s"},   32'(s_if.ARLEN),   32'(e_len));
        check({tag, ".arsize_s"},  32'(s_if.ARSIZE),  32'(e_size));
        check({tag, ".arburst_s"}, 32'(s_if.ARBURST), 32'(e_burst));
        check({tag, ".arready_m0"}, 32'(m0_if.ARREADY), 32'(v.e_ar0));
        check({tag, ".arready_m1"}, 32'(m1_if.ARREADY), 32'(v.e_ar1));
        check({tag, ".rvalid_m0"},  32'(m0_if.RVALID),  32'(v.e_rv0));
        check({tag, ".rvalid_m1"},  32'(m1_if.RVALID),  32'(v.e_rv1));
        check({tag, ".rready_s"},   32'(s_if.RREADY),   32'(v.e_rrs));
        check({tag, ".id_err"},     32'(id_err),        32'(v.e_err));
        if (v.e_rv0) begin
            check({tag, ".rid_m0"},   32'(m0_if.RID),   32'(v.rid[3:0]));
            check({tag, ".rdata_m0"}, m0_if.RDATA,      v.rdata);
            check({tag, ".rresp_m0"}, 32'(m0_if.RRESP), 32'(v.rdata[1:0]));
            check({tag, ".rlast_m0"}, 32'(m0_if.RLAST), 32'(v.rlast));
        end
        if (v.e_rv1) begin
            check({tag, ".rid_m1"},   32'(m1_if.RID),   32'(v.rid[3:0]));
            check({tag, ".rdata_m1"}, m1_if.RDATA,      v.rdata);
            check({tag, ".rresp_m1"}, 32'(m1_if.RRESP), 32'(v.rdata[1:0]));
            check({tag, ".rlast_m1"}, 32'(m1_if.RLAST), 32'(v.rlast));
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, ".arvalid_s"},  32'(s_if.ARVALID),  32'd0);
        check({tag, ".rready_s"},   32'(s_if.RREADY),   32'd0);
        check({tag, ".arready_m0"}, 32'(m0_if.ARREADY), 32'd0);
        check({tag, ".arready_m1"}, 32'(m1_if.ARREADY), 32'd0);
        check({tag, ".rvalid_m0"},  32'(m0_if.RVALID),  32'd0);
        check({tag, ".rvalid_m1"},  32'(m1_if.RVALID),  32'd0);
        check({tag, ".id_err"},     32'(id_err),        32'd0);
        check({tag, ".arid_s"},     32'(s_if.ARID),     32'd0);
        check({tag, ".araddr_s"},   s_if.ARADDR,        32'd0);
    endtask

    initial begin
        // Fixed per-master request fields.
        m0_if.ARID = 4'h3;  m0_if.ARADDR = 32'h0000_0040;
        m0_if.ARLEN = 4'd0; m0_if.ARSIZE = 3'd2; m0_if.ARBURST = 2'd1;
        m1_if.ARID = 4'h5;  m1_if.ARADDR = 32'h0000_0080;
        m1_if.ARLEN = 4'd3; m1_if.ARSIZE = 3'd1; m1_if.ARBURST = 2'd2;
        m0_if.ARVALID = 1'b0; m1_if.ARVALID = 1'b0;
        m0_if.RREADY  = 1'b0; m1_if.RREADY  = 1'b0;
        s_if.ARREADY = 1'b0; s_if.RVALID = 1'b0; s_if.RID = 8'h00;
        s_if.RDATA = 32'h0; s_if.RRESP = 2'b00; s_if.RLAST = 1'b0;

        // Three back-to-back contended reads: M0, M1, M0.
        tbl.push_back(mk(1,1,0,0,8'h00,0,0,0,32'h0,          0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,8'h00,0,0,0,32'h0,          1,8'h03,1,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,8'h03,1,1,1,32'h1111_0001,  0,8'h03,0,0,1,0,1,0));
        tbl.push_back(mk(1,1,0,0,8'h00,0,0,0,32'h0,          0,8'h03,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,8'h00,0,0,0,32'h0,          1,8'h15,0,1,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,8'h15,1,1,1,32'h2222_0002,  0,8'h15,0,0,0,1,1,0));
        tbl.push_back(mk(1,1,0,0,8'h00,0,0,0,32'h0,          0,8'h15,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,8'h00,0,0,0,32'h0,          1,8'h03,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,8'h03,1,1,0,32'h3333_0003,  0,8'h03,0,0,1,0,1,0));
        // Single M0 read.
        tbl.push_back(mk(1,0,0,0,8'h00,0,0,0,32'h0,          0,8'h03,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,0,8'h00,0,0,0,32'h0,          1,8'h03,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,8'h03,1,1,0,32'hDEAD_BEEF,  0,8'h03,0,0,1,0,1,0));
        // M1 4-beat burst, beat 2 stalled two cycles by RREADY_M1.
        tbl.push_back(mk(0,1,0,0,8'h00,0,0,0,32'h0,          0,8'h03,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,8'h00,0,0,0,32'h0,          1,8'h15,0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,8'h15,0,0,1,32'h0000_00B0,  0,8'h15,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h15,0,1,0,32'h0000_00B1,  0,8'h15,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,8'h15,0,0,0,32'h0000_00B1,  0,8'h15,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,8'h15,0,0,1,32'h0000_00B1,  0,8'h15,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h15,0,0,1,32'h0000_00B2,  0,8'h15,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h15,1,0,1,32'h0000_00B3,  0,8'h15,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h15,0,0,1,32'h0000_00B4,  0,8'h15,0,0,0,0,0,0));

        // Reset state.
        #2;
        check_all_idle("reset");
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Slave AR stall: request held stable, no ARREADY_M0 until the slave accepts.
        apply(mk(1,0,0,0,8'h00,0,0,0,32'h0, 0,8'h15,0,0,0,0,0,0), "stall0");
        for (int i = 1; i <= 3; i++) begin
            apply(mk(1,0,0,0,8'h00,0,0,0,32'h0, 1,8'h03,0,0,0,0,0,0), $sformatf("stall%0d", i));
        end
        apply(mk(1,0,1,0,8'h00,0,0,0,32'h0, 1,8'h03,1,0,0,0,0,0), "stall4");

        // Mismatched tag while M0 is granted: sunk, flagged, flag sticks.
        apply(mk(0,0,0,1,8'h25,0,1,0,32'h5555_0000, 0,8'h03,0,0,0,0,1,0), "tag0");
        apply(mk(0,0,0,1,8'h25,1,0,0,32'h5555_0001, 0,8'h03,0,0,0,0,1,1), "tag1");
        apply(mk(0,0,0,1,8'h03,1,1,0,32'h0000_C0DE, 0,8'h03,0,0,1,0,1,1), "tag2");
        apply(mk(0,0,0,0,8'h00,0,0,0,32'h0,         0,8'h03,0,0,0,0,0,1), "tag3");

        // Reset in the middle of an M0 burst (last grant is M0 before reset).
        apply(mk(1,0,0,0,8'h00,0,0,0,32'h0,         0,8'h03,0,0,0,0,0,1), "rst0");
        apply(mk(1,0,1,0,8'h00,0,0,0,32'h0,         1,8'h03,1,0,0,0,0,1), "rst1");
        apply(mk(0,0,0,1,8'h03,0,1,0,32'h0000_0A01, 0,8'h03,0,0,1,0,1,1), "rst2");
        m0_if.RREADY = 1'b1;
        s_if.RVALID  = 1'b1;
        s_if.RID     = 8'h03;
        s_if.RLAST   = 1'b0;
        s_if.RDATA   = 32'h0000_0A02;
        #2;
        check("rst3.rvalid_m0_pre", 32'(m0_if.RVALID), 32'd1);
        ARESETn = 1'b0;
        #1;
        check_all_idle("rst_async");
        @(posedge ACLK);
        #1;
        check_all_idle("rst_held");
        s_if.RVALID   = 1'b0;
        m0_if.RREADY  = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        // First contention after reset goes to M0 again.
        apply(mk(1,1,0,0,8'h00,0,0,0,32'h0,         0,8'h00,0,0,0,0,0,0), "post0");
        apply(mk(1,1,1,0,8'h00,0,0,0,32'h0,         1,8'h03,1,0,0,0,0,0), "post1");
        apply(mk(0,0,0,1,8'h03,1,1,1,32'h0000_0B0B, 0,8'h03,0,0,1,0,1,0), "post2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI read channels (AR and R) of the shared instruction/data memory slave.
- M0 is the CPU instruction-fetch port and M1 is the CPU data port. Both have 4-bit IDs; the slave side uses 8-bit IDS.
- One read transaction is outstanding at a time. The grant is held from the AR handshake until the slave R handshake with RLAST.
- Round-robin between the two masters; M0 wins the first contention after reset.

Parameters:
- MASTER_TAG0, 4'h0, IDS[7:4] tag prepended to M0 IDs.
- MASTER_TAG1, 4'h1, IDS[7:4] tag prepended to M1 IDs.

Ports:
- ACLK  in  1  clock; single clock domain.
- ARESETn  in  1  asynchronous, active-low reset.
- ARID_M0/ARID_M1  in  4  master read IDs.
- ARADDR_M0/ARADDR_M1  in  32  master read addresses.
- ARLEN_M0/ARLEN_M1  in  4  burst lengths.
- ARSIZE_M0/ARSIZE_M1  in  3  burst sizes.
- ARBURST_M0/ARBURST_M1  in  2  burst types.
- ARVALID_M0/ARVALID_M1  in  1  master AR requests.
- ARREADY_M0/ARREADY_M1  out  1  master AR accepts.
- RID_M0/RID_M1  out  4  = slave RID[3:0].
- RDATA_M0/RDATA_M1  out  32  read data.
- RRESP_M0/RRESP_M1  out  2  read responses.
- RLAST_M0/RLAST_M1  out  1  last beat.
- RVALID_M0/RVALID_M1  out  1  read data valid.
- RREADY_M0/RREADY_M1  in  1  master read-data accepts.
- ARID_S  out  8  {tag, ARID_Mx}.
- ARADDR_S  out  32  forwarded address.
- ARLEN_S  out  4  forwarded length.
- ARSIZE_S  out  3  forwarded size.
- ARBURST_S  out  2  forwarded burst type.
- ARVALID_S  out  1  slave AR request.
- ARREADY_S  in  1  slave AR accept.
- RID_S  in  8  slave read ID.
- RDATA_S  in  32  slave read data.
- RRESP_S  in  2  slave read response.
- RLAST_S  in  1  slave last beat.
- RVALID_S  in  1  slave read data valid.
- RREADY_S  out  1  slave read-data accept.
- id_err  out  1  sticky flag: R beat received with an unexpected tag.

Behaviour:
- Reset (asynchronous, ARESETn=0):
  - state=IDLE, grant=0, last_grant=1, id_err=0.
  - All VALID/READY outputs 0; all data/ID outputs 0.
  - Reset asserted mid-transaction aborts it immediately; no beat is forwarded afterwards.
- States: IDLE, ADDR, DATA (registered, 2 bits).
- IDLE:
  - Master outputs: no ARREADY_Mx, no RVALID_Mx. Slave outputs: ARVALID_S=0, RREADY_S=0.
  - On a clock edge with a request:
    - Only ARVALID_M0: grant=0.
    - Only ARVALID_M1: grant=1.
    - Both: grant=~last_grant.
  - Then latch ARID/ARADDR/ARLEN/ARSIZE/ARBURST of the granted master into slave-side registers and go to ADDR. Slave ARVALID_S is therefore 1 cycle after the request.
- ADDR:
  - ARVALID_S=1 with the latched fields; ARID_S={tag(grant), latched ARID}.
  - ARREADY_Mgrant = ARREADY_S (combinational); the other master's ARREADY=0.
  - On ARVALID_S && ARREADY_S: last_grant<=grant, go to DATA.
  - Latched fields are stable while ARVALID_S is high; the master sees the handshake in the same cycle the slave accepts.
- DATA:
  - If RID_S[7:4]==tag(grant):
    - RVALID_Mgrant=RVALID_S.
    - RID/RDATA/RRESP/RLAST forwarded to the granted master.
    - RREADY_S=RREADY_Mgrant.
  - Non-granted master: RVALID=0.
  - If RVALID_S with a mismatched tag:
    - RREADY_S=1 (beat sunk), nothing forwarded, id_err<=1.
  - Exit: on a matching-tag handshake with RLAST_S=1, go to IDLE. A new grant is possible on the next edge, so the minimum gap between transactions is 1 idle cycle.
- Multi-beat bursts:
  - Forward every beat; stay in DATA until RLAST.
  - ARLEN is not counted; RLAST alone terminates.
- A master that drops ARVALID before the grant:
  - The request is still served once latched in IDLE. Masters are AXI-compliant and must not drop ARVALID.
- Master R outputs carry don't-care data when RVALID=0; they are driven from the slave bus, not gated.
- id_err clears only on reset.

Test Plan:
- Single M0 read:
  - Stimulus: ARVALID_M0=1, ARID_M0=4'h3, ARADDR=32'h0000_0040; slave returns RDATA=32'hDEAD_BEEF with RLAST.
  - Required: ARID_S=8'h03 one cycle later; RID_M0=4'h3, RDATA_M0=32'hDEAD_BEEF; RVALID_M1 held 0 throughout.
- Simultaneous requests, three back-to-back:
  - Stimulus: both masters request three times in a row.
  - Required: grants in order M0, M1, M0; ARID_S tags 0x0_, 0x1_, 0x0_.
- 4-beat burst for M1 with RREADY_M1 stalls:
  - Stimulus: ARLEN=4'd3; RREADY_M1 held low for 2 cycles on beat 2.
  - Required: RREADY_S mirrors RREADY_M1; 4 beats delivered in order; IDLE only after the RLAST handshake.
- Slave ARREADY stall:
  - Stimulus: ARREADY_S low for 3 cycles.
  - Required: ARVALID_S and ARADDR_S stable; ARREADY_M0 stays 0 until ARREADY_S=1.
- Mismatched tag:
  - Stimulus: slave returns RID_S=8'h25 while M0 is granted.
  - Required: beat sunk (RREADY_S=1), RVALID_M0=0, id_err=1 and stays 1.
- Reset mid-DATA:
  - Stimulus: ARESETn=0 during beat 2 of a burst.
  - Required: all VALID/READY outputs 0 immediately; after release, the next simultaneous request is granted to M0.
